// File: rtl/tdm_demux_1to6.sv
// Receive side of the 6:1 TDM link: aligns on frame_sync, gathers slots in a shadow bank, commits full frames.
// Optional SYNC_ERR_EN adds a sticky misalignment flag on sync_err (tied to 0 otherwise).
module tdm_demux_1to6 #(
    parameter int unsigned W     = 1,
    parameter int unsigned NSLOT = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [W-1:0]       din,
    input  logic               frame_sync,
    output logic [NSLOT*W-1:0] dout,
    output logic               frame_valid,
    output logic [2:0]         slot,
    output logic               locked,
    output logic               sync_err
);

    typedef enum logic {HUNT, RUN} state_t;

    localparam logic [2:0] LAST = 3'(NSLOT - 1);

    state_t               state, state_n;
    logic [2:0]           slot_n;
    logic [W-1:0]         shadow [NSLOT-1];
    logic [NSLOT*W-1:0]   frame_n;
    logic                 wr_en;
    logic [2:0]           wr_idx;
    logic                 commit;
    logic                 misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        slot_n   = slot;
        wr_en    = 1'b0;
        wr_idx   = '0;
        commit   = 1'b0;
        misalign = en && frame_sync && (state == RUN) && (slot != 3'd0);
        if (en) begin
            if (state == HUNT) begin
                if (frame_sync) begin
                    wr_en   = 1'b1;
                    slot_n  = 3'd1;
                    state_n = RUN;
                end
            end else begin
                // A sync seen anywhere but slot 0 (slot 5 included) restarts the frame at slot 0.
                commit = !misalign && (slot == LAST);
                wr_en  = !commit;
                wr_idx = misalign ? 3'd0 : slot;
                if (misalign) begin
                    slot_n = 3'd1;
                end else if (commit) begin
                    slot_n = 3'd0;
                end else begin
                    slot_n = slot + 3'd1;
                end
            end
        end
    end

    always_comb begin
        frame_n = '0;
        for (int unsigned k = 0; k < NSLOT - 1; k++) begin
            frame_n[k*W +: W] = shadow[k];
        end
        frame_n[(NSLOT-1)*W +: W] = din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot        <= '0;
            dout        <= '0;
            frame_valid <= 1'b0;
            for (int unsigned k = 0; k < NSLOT - 1; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            slot        <= slot_n;
            frame_valid <= commit;
            if (commit) begin
                dout <= frame_n;
            end
            for (int unsigned k = 0; k < NSLOT - 1; k++) begin
                if (wr_en && (wr_idx == 3'(k))) begin
                    shadow[k] <= din;
                end
            end
        end
    end

    assign locked = (state == RUN);

`ifdef SYNC_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (misalign) begin
            err_q <= 1'b1;
        end
    end

    assign sync_err = err_q;
`else
    assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_1to6.sv
// Scoreboard bench for tdm_demux_1to6: expected frames queued when slot 5 is driven, popped on frame_valid.
module tb_tdm_demux_1to6;

    logic       clk;
    logic       rst;
    logic       en;
    logic [0:0] din;
    logic       frame_sync;
    logic [5:0] dout;
    logic       frame_valid;
    logic [2:0] slot;
    logic       locked;
    logic       sync_err;

`ifdef SYNC_ERR_EN
    localparam logic SE = 1'b1;
`else
    localparam logic SE = 1'b0;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [5:0]  sb [$];

    tdm_demux_1to6 #(.W(1), .NSLOT(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din        (din),
        .frame_sync (frame_sync),
        .dout       (dout),
        .frame_valid(frame_valid),
        .slot       (slot),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive, step past the edge, check slot and strobe.
    task automatic beat(input logic e, input logic fs, input logic d,
                        input logic [2:0] exp_slot, input logic exp_fv);
        en         = e;
        frame_sync = fs;
        din        = d;
        @(posedge clk);
        #1;
        check("slot", 32'(slot), 32'(exp_slot));
        check("frame_valid", 32'(frame_valid), 32'(exp_fv));
    endtask

    // Drives slots first..5 of frame d (channel k = d[k]); slot 5 beat queues the expected frame.
    task automatic frame(input logic [5:0] d, input int unsigned first, input logic fs0);
        for (int unsigned i = first; i < 6; i++) begin
            if (i == 5) sb.push_back(d);
            beat(1'b1, fs0 && (i == first), d[i], 3'((i + 1) % 6), i == 5);
        end
    endtask

    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            if (sb.size() == 0) check("sb_unexpected", 32'd1, 32'd0);
            else check("sb_dout", 32'(dout), 32'(sb.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] d;
        logic [5:0] prev;
        rst = 1'b1; en = 1'b0; frame_sync = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_slot", 32'(slot), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_fv", 32'(frame_valid), 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        rst = 1'b0;

        // Hunting: data without frame_sync is ignored
        for (int i = 0; i < 10; i++) begin
            d = 6'(i);
            beat(1'b1, 1'b0, d[0], 3'd0, 1'b0);
        end
        check("hunt_locked", 32'(locked), 32'd0);
        check("hunt_dout", 32'(dout), 32'd0);

        // First frame: din 1,0,1,1,0,1 on slots 0..5
        frame(6'b101101, 0, 1'b1);
        check("f1_dout", 32'(dout), 32'h2d);
        check("f1_locked", 32'(locked), 32'd1);
        beat(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("f1_hold", 32'(dout), 32'h2d);

        // Back-to-back frames, then one free-running frame without frame_sync
        for (int f = 0; f < 3; f++) begin
            d = 6'($urandom);
            frame(d, 0, 1'b1);
            check("b2b_locked", 32'(locked), 32'd1);
        end
        d = 6'($urandom);
        frame(d, 0, 1'b0);
        check("freerun_dout", 32'(dout), 32'(d));
        check("aligned_sync_err", 32'(sync_err), 32'd0);

        // Misaligned sync at slot 3
        prev = dout;
        d = 6'($urandom);
        beat(1'b1, 1'b1, ~d[1], 3'd1, 1'b0);
        beat(1'b1, 1'b0, d[2], 3'd2, 1'b0);
        beat(1'b1, 1'b0, d[3], 3'd3, 1'b0);
        beat(1'b1, 1'b1, d[0], 3'd1, 1'b0);
        check("mis3_dout", 32'(dout), 32'(prev));
        check("mis3_sync_err", 32'(sync_err), 32'(SE));
        frame(d, 1, 1'b0);
        check("mis3_sticky", 32'(sync_err), 32'(SE));

        // Sync landing on slot 5 is also a misalignment; slot 5 data is dropped
        prev = dout;
        d = 6'($urandom);
        for (int unsigned i = 0; i < 5; i++) begin
            beat(1'b1, i == 0, ~d[i], 3'(i + 1), 1'b0);
        end
        beat(1'b1, 1'b1, d[0], 3'd1, 1'b0);
        check("mis5_dout", 32'(dout), 32'(prev));
        frame(d, 1, 1'b0);

        // en low for 3 cycles after slot 2 (frame_sync high meanwhile must be ignored)
        d = 6'($urandom);
        for (int unsigned i = 0; i < 3; i++) begin
            beat(1'b1, i == 0, d[i], 3'(i + 1), 1'b0);
        end
        repeat (3) beat(1'b0, 1'b1, ~d[3], 3'd3, 1'b0);
        frame(d, 3, 1'b0);
        check("pause_dout", 32'(dout), 32'(d));

        // Reset mid-frame at slot 4
        d = 6'($urandom);
        for (int unsigned i = 0; i < 4; i++) begin
            beat(1'b1, i == 0, d[i], 3'(i + 1), 1'b0);
        end
        rst = 1'b1;
        beat(1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
        check("mrst_locked", 32'(locked), 32'd0);
        check("mrst_dout", 32'(dout), 32'd0);
        check("mrst_sync_err", 32'(sync_err), 32'd0);
        rst = 1'b0;
        d = 6'($urandom);
        frame(d, 0, 1'b1);
        check("post_rst_dout", 32'(dout), 32'(d));

        beat(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
